// File: rtl/deparser_emit_segs.sv
// deparser_emit_segs
//   Transmit-side counterpart of the parser segment collector. Pops one
//   C_NUM_SEGS x DW header block (already rewritten by the deparser) plus the
//   first-beat tuser from the segs FIFO. Sends that block as the first
//   C_NUM_SEGS AXIS beats of the packet, with tkeep/tlast taken from the
//   original packet beats at the payload FIFO head. The rest of the payload
//   then passes through unchanged.
//
//   Optional build macro: DEPARSER_DISCARD_EN. When it is defined, a packet
//   whose tuser_1st[C_DISCARD_BIT] is set is drained from the payload FIFO
//   and is not emitted.
//
// Ports
//   axis_clk, aresetn         clock, asynchronous active-low reset
//   tdata_segs, tuser_1st     header block (seg k = [k*DW +: DW]) and first-beat tuser
//   segs_fifo_empty/_rd       segs FIFO status (fall-through) / pop pulse
//   pkt_fifo_tdata/tkeep/tlast/empty, pkt_fifo_rd
//                             payload FIFO head / pop (pop == output handshake)
//   m_axis_*                  AXIS master output
//   pkt_cnt                   packets fully emitted, wraps
module deparser_emit_segs #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS           = 4,
  parameter int C_DISCARD_BIT        = 127
) (
  input  logic                                      axis_clk,
  input  logic                                      aresetn,
  input  logic [C_NUM_SEGS*C_S_AXIS_DATA_WIDTH-1:0] tdata_segs,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
  input  logic                                      segs_fifo_empty,
  output logic                                      segs_fifo_rd,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]            pkt_fifo_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          pkt_fifo_tkeep,
  input  logic                                      pkt_fifo_tlast,
  input  logic                                      pkt_fifo_empty,
  output logic                                      pkt_fifo_rd,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [31:0]                               pkt_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int SEG_W = (C_NUM_SEGS > 1) ? $clog2(C_NUM_SEGS) : 1;
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(C_NUM_SEGS - 1);

  // Catch bad configurations at elaboration rather than in the lab.
  if (C_NUM_SEGS < 1 || C_DISCARD_BIT < 0 || C_DISCARD_BIT >= C_S_AXIS_TUSER_WIDTH) begin : g_bad_cfg
    $error("deparser_emit_segs: C_NUM_SEGS must be >=1 and C_DISCARD_BIT inside tuser");
  end

`ifdef DEPARSER_DISCARD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_PAYLOAD = 2'd2, S_DROP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_PAYLOAD = 2'd2} state_e;
`endif

  state_e                         state_q, state_d;
  logic [SEG_W-1:0]               seg_cnt_q, seg_cnt_d;
  logic [C_NUM_SEGS-1:0][DW-1:0]  hdr_q, hdr_d;
  logic [UW-1:0]                  tuser_q, tuser_d;
  logic [31:0]                    pkt_cnt_q, pkt_cnt_d;
  logic                           vld;
  logic                           hs;

  assign pkt_cnt = pkt_cnt_q;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      seg_cnt_q <= '0;
      hdr_q     <= '0;
      tuser_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      hdr_q     <= hdr_d;
      tuser_q   <= tuser_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    seg_cnt_d     = seg_cnt_q;
    hdr_d         = hdr_q;
    tuser_d       = tuser_q;
    pkt_cnt_d     = pkt_cnt_q;
    vld           = 1'b0;
    hs            = 1'b0;
    segs_fifo_rd  = 1'b0;
    pkt_fifo_rd   = 1'b0;
    m_axis_tdata  = pkt_fifo_tdata;
    m_axis_tkeep  = pkt_fifo_tkeep;
    m_axis_tlast  = pkt_fifo_tlast;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only commit to a packet once its first payload beat is present, so
        // the first header beat can go out the very next cycle.
        if (!segs_fifo_empty && !pkt_fifo_empty) begin
          segs_fifo_rd = 1'b1;
          hdr_d        = tdata_segs;
          tuser_d      = tuser_1st;
          seg_cnt_d    = '0;
`ifdef DEPARSER_DISCARD_EN
          state_d      = tuser_1st[C_DISCARD_BIT] ? S_DROP : S_EMIT;
`else
          state_d      = S_EMIT;
`endif
        end
      end

      S_EMIT: begin
        // Header data replaces the payload data beat-for-beat; tkeep/tlast
        // still come from the payload so short packets end correctly.
        vld           = !pkt_fifo_empty;
        hs            = vld && m_axis_tready;
        m_axis_tvalid = vld;
        m_axis_tdata  = hdr_q[seg_cnt_q];
        m_axis_tuser  = (seg_cnt_q == '0) ? tuser_q : '0;
        pkt_fifo_rd   = hs;
        if (hs) begin
          if (pkt_fifo_tlast) begin
            // Remaining header segments of a short packet are dropped.
            state_d   = S_IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else if (seg_cnt_q == LAST_SEG) begin
            state_d   = S_PAYLOAD;
          end else begin
            seg_cnt_d = seg_cnt_q + SEG_W'(1);
          end
        end
      end

      S_PAYLOAD: begin
        vld           = !pkt_fifo_empty;
        hs            = vld && m_axis_tready;
        m_axis_tvalid = vld;
        pkt_fifo_rd   = hs;
        if (hs && pkt_fifo_tlast) begin
          state_d   = S_IDLE;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      end

`ifdef DEPARSER_DISCARD_EN
      S_DROP: begin
        // Drain the discarded packet at full rate; nothing reaches the output.
        pkt_fifo_rd = !pkt_fifo_empty;
        if (!pkt_fifo_empty && pkt_fifo_tlast) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_deparser_emit_segs.sv
// Bench for deparser_emit_segs: FIFO models as queues, expected output beats
// queued when a packet is loaded and compared when the DUT hands a beat off.
module tb_deparser_emit_segs;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NS = 4;
  localparam int KW = DW / 8;

  logic              axis_clk = 1'b0;
  logic              aresetn;
  logic [NS*DW-1:0]  tdata_segs;
  logic [UW-1:0]     tuser_1st;
  logic              segs_fifo_empty;
  logic              segs_fifo_rd;
  logic [DW-1:0]     pkt_fifo_tdata;
  logic [KW-1:0]     pkt_fifo_tkeep;
  logic              pkt_fifo_tlast;
  logic              pkt_fifo_empty;
  logic              pkt_fifo_rd;
  logic [DW-1:0]     m_axis_tdata;
  logic [UW-1:0]     m_axis_tuser;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [31:0]       pkt_cnt;

  deparser_emit_segs #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_NUM_SEGS          (NS),
    .C_DISCARD_BIT       (127)
  ) dut (
    .axis_clk       (axis_clk),
    .aresetn        (aresetn),
    .tdata_segs     (tdata_segs),
    .tuser_1st      (tuser_1st),
    .segs_fifo_empty(segs_fifo_empty),
    .segs_fifo_rd   (segs_fifo_rd),
    .pkt_fifo_tdata (pkt_fifo_tdata),
    .pkt_fifo_tkeep (pkt_fifo_tkeep),
    .pkt_fifo_tlast (pkt_fifo_tlast),
    .pkt_fifo_empty (pkt_fifo_empty),
    .pkt_fifo_rd    (pkt_fifo_rd),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .pkt_cnt        (pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  typedef struct packed {
    logic [NS*DW-1:0] d;
    logic [UW-1:0]    u;
  } seg_t;

  seg_t  sq[$];
  beat_t pq[$];
  beat_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int segs_rd_cnt = 0, pkt_rd_cnt = 0, vld_cnt = 0;
  int pop_cyc = 0, vld_gap = 0, last_cyc = 0, pkt_gap = 0;
  int rd_first = -1, rd_last = -1;
  bit after_last = 0, prev_vld = 0, prev_stall = 0;
  bit seg_pop = 0, pkt_pop = 0;
  bit bp_en = 0;
  int bp_i = 0;
  beat_t prev_out;

  function automatic logic [31:0] mk(input logic [7:0] tag, input int p, input int i);
    return {tag, 8'(p), 8'hC3, 8'(i)};
  endfunction

  function automatic logic [DW-1:0] seg_data(input int p, input int k);
    return {8{mk(8'hA0, p, k)}};
  endfunction

  function automatic logic [DW-1:0] pay_data(input int p, input int i);
    return {8{mk(8'hB0, p, i)}};
  endfunction

  task automatic refresh();
    segs_fifo_empty = (sq.size() == 0);
    tdata_segs      = segs_fifo_empty ? '0 : sq[0].d;
    tuser_1st       = segs_fifo_empty ? '0 : sq[0].u;
    pkt_fifo_empty  = (pq.size() == 0);
    pkt_fifo_tdata  = pkt_fifo_empty ? '0 : pq[0].d;
    pkt_fifo_tkeep  = pkt_fifo_empty ? '0 : pq[0].k;
    pkt_fifo_tlast  = pkt_fifo_empty ? 1'b0 : pq[0].l;
  endtask

  task automatic push_segs(input int p, input logic [UW-1:0] tu);
    seg_t s;
    for (int k = 0; k < NS; k++) s.d[k*DW +: DW] = seg_data(p, k);
    s.u = tu;
    sq.push_back(s);
    refresh();
  endtask

  // Payload beats for packet p; the expected output is built from the header
  // segments of p for the first NS beats and the payload beyond that.
  task automatic push_payload(input int p, input int nb, input logic [KW-1:0] klast,
                              input logic [UW-1:0] tu, input bit expect_out);
    beat_t b, e;
    for (int i = 0; i < nb; i++) begin
      b.d = pay_data(p, i);
      b.k = (i == nb - 1) ? klast : '1;
      b.l = (i == nb - 1);
      b.u = '0;
      pq.push_back(b);
      if (expect_out) begin
        e   = b;
        e.d = (i < NS) ? seg_data(p, i) : pay_data(p, i);
        e.u = (i == 0) ? tu : '0;
        exp_q.push_back(e);
      end
    end
    refresh();
  endtask

  // One clock: monitor outputs mid-cycle, then apply FIFO pops after the edge.
  task automatic tick();
    beat_t e, cur;
    @(negedge axis_clk);
    cyc++;
    cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast, u: m_axis_tuser};
    seg_pop = segs_fifo_rd;
    pkt_pop = pkt_fifo_rd;
    if (segs_fifo_rd) begin segs_rd_cnt++; pop_cyc = cyc; end
    if (pkt_fifo_rd) begin
      pkt_rd_cnt++;
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
    end
    if (m_axis_tvalid) vld_cnt++;
    if (m_axis_tvalid && !prev_vld) vld_gap = cyc - pop_cyc;
    if (prev_stall) begin
      checks++;
      if (!m_axis_tvalid || cur !== prev_out) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d: got vld=%0b data=%h, required vld=1 data=%h",
                 cyc, m_axis_tvalid, cur.d, prev_out.d);
      end
    end
    if (m_axis_tvalid) begin
      checks++;
      if (pkt_fifo_rd !== m_axis_tready) begin
        errors++;
        $display("FAIL rd_on_handshake cyc=%0d: pkt_fifo_rd=%0b, required %0b", cyc, pkt_fifo_rd, m_axis_tready);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d: got data=%h, required no beat", cyc, cur.d);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL beat cyc=%0d: got d=%h k=%h l=%0b u=%h, required d=%h k=%h l=%0b u=%h",
                   cyc, cur.d, cur.k, cur.l, cur.u, e.d, e.k, e.l, e.u);
        end
      end
      if (after_last) begin pkt_gap = cyc - last_cyc; after_last = 0; end
      if (m_axis_tlast) begin after_last = 1; last_cyc = cyc; end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out   = cur;
    prev_vld   = m_axis_tvalid;
    @(posedge axis_clk);
    #1;
    if (seg_pop && sq.size() > 0) void'(sq.pop_front());
    if (pkt_pop && pq.size() > 0) void'(pq.pop_front());
    refresh();
    if (bp_en) begin m_axis_tready = (bp_i % 2 == 0); bp_i++; end
    #1;
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() > 0 || pq.size() > 0) && n < budget) begin tick(); n++; end
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", nm, exp_q.size() + pq.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    checks += 4;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b, required 0", m_axis_tvalid); end
    if (segs_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_segs_rd: got %0b, required 0", segs_fifo_rd); end
    if (pkt_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_pkt_rd: got %0b, required 0", pkt_fifo_rd); end
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c0 = pkt_cnt, s0 = segs_rd_cnt, r0 = pkt_rd_cnt;
    push_segs(1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    push_payload(1, 6, '1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1);
    drain(40, "basic");
    checks += 4;
    if (pkt_cnt !== c0 + 1) begin errors++; $display("FAIL basic_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 1); end
    if (segs_rd_cnt - s0 != 1) begin errors++; $display("FAIL basic_segs_rd: got %0d pops, required 1", segs_rd_cnt - s0); end
    if (pkt_rd_cnt - r0 != 6) begin errors++; $display("FAIL basic_pkt_rd: got %0d pops, required 6", pkt_rd_cnt - r0); end
    if (vld_gap != 1) begin errors++; $display("FAIL basic_latency: got %0d cycles, required 1", vld_gap); end
  endtask

  task automatic test_short();
    int c0 = pkt_cnt;
    push_segs(2, 128'h0000_0000_0000_0000_0000_0000_0000_00A2);
    push_payload(2, 2, 32'h0000_FFFF, 128'h0000_0000_0000_0000_0000_0000_0000_00A2, 1);
    push_segs(3, 128'h0000_0000_0000_0000_0000_0000_0000_00A3);
    push_payload(3, 6, 32'h0000_00FF, 128'h0000_0000_0000_0000_0000_0000_0000_00A3, 1);
    drain(40, "short");
    checks += 2;
    if (pkt_cnt !== c0 + 2) begin errors++; $display("FAIL short_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 2); end
    if (pkt_gap != 2) begin errors++; $display("FAIL short_pkt_gap: got %0d cycles, required 2", pkt_gap); end
  endtask

  task automatic test_backpressure();
    int c0 = pkt_cnt, r0 = pkt_rd_cnt;
    bp_en = 1;
    bp_i  = 0;
    push_segs(4, 128'h0000_0000_0000_0000_0000_0000_0000_00B4);
    push_payload(4, 6, '1, 128'h0000_0000_0000_0000_0000_0000_0000_00B4, 1);
    drain(60, "backpressure");
    bp_en = 0;
    m_axis_tready = 1'b1;
    checks += 2;
    if (pkt_cnt !== c0 + 1) begin errors++; $display("FAIL bp_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 1); end
    if (pkt_rd_cnt - r0 != 6) begin errors++; $display("FAIL bp_pkt_rd: got %0d pops, required 6", pkt_rd_cnt - r0); end
  endtask

  task automatic test_payload_starve();
    logic [UW-1:0] tu = 128'h0000_0000_0000_0000_0000_0000_0000_00C5;
    push_segs(5, tu);
    #1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (segs_fifo_rd !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL starve_idle cyc=%0d: got segs_rd=%0b tvalid=%0b, required 0 0", cyc, segs_fifo_rd, m_axis_tvalid);
      end
    end
    push_payload(5, 3, '1, tu, 1);
    #1;
    checks++;
    if (segs_fifo_rd !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL starve_pop: got segs_rd=%0b tvalid=%0b, required 1 0", segs_fifo_rd, m_axis_tvalid);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== seg_data(5, 0)) begin
      errors++;
      $display("FAIL starve_first: got tvalid=%0b data=%h, required 1 %h", m_axis_tvalid, m_axis_tdata, seg_data(5, 0));
    end
    drain(30, "starve");
  endtask

  task automatic test_async_reset();
    int n = 0;
    push_segs(6, 128'h0000_0000_0000_0000_0000_0000_0000_00D6);
    push_payload(6, 6, '1, 128'h0000_0000_0000_0000_0000_0000_0000_00D6, 1);
    while (exp_q.size() > 4 && n < 20) begin tick(); n++; end
    #2;
    aresetn = 1'b0;
    #1;
    checks += 2;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL areset_tvalid: got %0b, required 0", m_axis_tvalid); end
    if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL areset_pkt_cnt: got %0d, required 0", pkt_cnt); end
    sq.delete();
    pq.delete();
    exp_q.delete();
    refresh();
    prev_stall = 0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    push_segs(7, 128'h0000_0000_0000_0000_0000_0000_0000_00E7);
    push_payload(7, 5, 32'h0000_0FFF, 128'h0000_0000_0000_0000_0000_0000_0000_00E7, 1);
    drain(40, "after_reset");
    checks++;
    if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL after_reset_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  task automatic test_discard();
    logic [UW-1:0] tu = {1'b1, 127'h5A};
    int c0 = pkt_cnt, r0 = pkt_rd_cnt, v0 = vld_cnt;
    rd_first = -1;
`ifdef DEPARSER_DISCARD_EN
    push_segs(8, tu);
    push_payload(8, 5, '1, tu, 0);
    drain(30, "discard");
    checks += 4;
    if (pkt_rd_cnt - r0 != 5) begin errors++; $display("FAIL discard_rd: got %0d pops, required 5", pkt_rd_cnt - r0); end
    if (rd_last - rd_first != 4) begin errors++; $display("FAIL discard_consec: got span %0d, required 4", rd_last - rd_first); end
    if (vld_cnt != v0) begin errors++; $display("FAIL discard_tvalid: got %0d valid cycles, required 0", vld_cnt - v0); end
    if (pkt_cnt !== c0) begin errors++; $display("FAIL discard_pkt_cnt: got %0d, required %0d", pkt_cnt, c0); end
`else
    push_segs(8, tu);
    push_payload(8, 5, '1, tu, 1);
    drain(30, "no_discard");
    checks += 2;
    if (pkt_rd_cnt - r0 != 5) begin errors++; $display("FAIL no_discard_rd: got %0d pops, required 5", pkt_rd_cnt - r0); end
    if (pkt_cnt !== c0 + 1) begin errors++; $display("FAIL no_discard_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 1); end
`endif
  endtask

  initial begin
    m_axis_tready = 1'b1;
    refresh();
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_payload_starve();
    test_async_reset();
    test_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
